// File: rtl/banco_registros_param_if.sv
// Decode/writeback bus of the parametrised register bank.
// Holds the read, write and issue request signals plus the read data and scoreboard results.
interface banco_registros_param_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]     A1;
    logic [AW-1:0]     A2;
    logic [AW-1:0]     A3;
    logic [XLEN-1:0]   WD3;
    logic              WE3;
    logic [XLEN/8-1:0] BE3;
    logic              ISS_EN;
    logic [AW-1:0]     ISS_A;
    logic [XLEN-1:0]   RD1;
    logic [XLEN-1:0]   RD2;
    logic              BUSY1;
    logic              BUSY2;
    logic [NREGS-1:0]  BUSY_VEC;

    modport master (
        output A1, A2, A3, WD3, WE3, BE3, ISS_EN, ISS_A,
        input  RD1, RD2, BUSY1, BUSY2, BUSY_VEC
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, BE3, ISS_EN, ISS_A,
        output RD1, RD2, BUSY1, BUSY2, BUSY_VEC
    );
endinterface

// File: rtl/banco_registros_param.sv
// Parametrised 1W/2R register bank with byte-enabled writes, optional write-to-read
// bypass, optional hardwired-zero r0 and a per-register pending-write scoreboard.
module banco_registros_param #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = $clog2(NREGS),
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                    CLK,
    input  logic                    reset,
    banco_registros_param_if.slave  rf
);
    localparam int NB = XLEN / 8;

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_nxt;
    logic [XLEN-1:0]            wmask;
    logic [XLEN-1:0]            merged;
    logic                       wr_ok;
    logic                       fwd1;
    logic                       fwd2;
    logic                       zero1;
    logic                       zero2;

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign wmask[8*b +: 8] = {8{rf.BE3[b]}};
    end

    // Post-edge value of the write target; also what the bypass forwards.
    assign merged = (regs[rf.A3] & ~wmask) | (rf.WD3 & wmask);
    assign wr_ok  = rf.WE3 && !(ZERO_R0 != 0 && rf.A3 == '0);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[rf.A3] <= merged;
        end
    end

    // Issue beats completion on the same register: the new write is the outstanding one.
    always_comb begin
        busy_nxt = busy;
        if (rf.WE3)
            busy_nxt[rf.A3] = 1'b0;
        if (rf.ISS_EN)
            busy_nxt[rf.ISS_A] = 1'b1;
        if (ZERO_R0 != 0)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign fwd1  = (BYPASS != 0) && rf.WE3 && (rf.A1 == rf.A3);
    assign fwd2  = (BYPASS != 0) && rf.WE3 && (rf.A2 == rf.A3);
    assign zero1 = (ZERO_R0 != 0) && (rf.A1 == '0);
    assign zero2 = (ZERO_R0 != 0) && (rf.A2 == '0);

    // Outputs are gated by reset so a bypassed write cannot leak through while held.
    always_comb begin
        rf.RD1   = '0;
        rf.RD2   = '0;
        rf.BUSY1 = 1'b0;
        rf.BUSY2 = 1'b0;
        if (reset && !zero1) begin
            rf.RD1   = fwd1 ? merged : regs[rf.A1];
            rf.BUSY1 = fwd1 ? 1'b0 : busy[rf.A1];
        end
        if (reset && !zero2) begin
            rf.RD2   = fwd2 ? merged : regs[rf.A2];
            rf.BUSY2 = fwd2 ? 1'b0 : busy[rf.A2];
        end
    end

    assign rf.BUSY_VEC = busy;
endmodule

// File: doc/banco_registros_param.md
Name: banco_registros_param

Overview:
- Parametrised successor to the single-write, dual-read register bank of the datapath.
- Adds configurable width and depth, byte-enabled writes, optional write-to-read bypass, and an optional hardwired-zero register 0.
- Adds a per-register pending-write scoreboard so the decode stage can detect RAW hazards against in-flight writes.
- Sits between decode (read ports, issue) and writeback (write port).

Parameters:
XLEN, 32, data width in bits; must be a multiple of 8
NREGS, 32, number of registers; power of two, 2..64
AW, $clog2(NREGS), address width (derived; do not override)
BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads return the stored value
ZERO_R0, 1, 1 = register 0 always reads 0, ignores writes and never becomes busy

Ports:
CLK  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
A1  in  AW  read address, port 1
A2  in  AW  read address, port 2
A3  in  AW  write address
WD3  in  XLEN  write data
WE3  in  1  write enable
BE3  in  XLEN/8  byte enables for the write; bit i covers WD3[8i+7:8i]
ISS_EN  in  1  issue: mark register ISS_A as pending-write
ISS_A  in  AW  register being issued
RD1  out  XLEN  read data, port 1 (combinational)
RD2  out  XLEN  read data, port 2 (combinational)
BUSY1  out  1  register A1 has a pending write (combinational)
BUSY2  out  1  register A2 has a pending write (combinational)
BUSY_VEC  out  NREGS  registered scoreboard state

Behaviour:
- Reset (reset=0, asynchronous): all registers cleared to 0 and BUSY_VEC=0 immediately, independent of CLK. While reset is held low, RD1, RD2, BUSY1 and BUSY2 read 0.
- Reset release is synchronous to the next rising edge: the first write or issue can take effect on the first edge after reset goes high.
- Write, on the rising edge with WE3=1: for each i with BE3[i]=1, reg[A3] byte i <= WD3 byte i. Bytes with BE3[i]=0 are unchanged.
- WE3=1 with BE3=0 writes nothing, but it still counts as a completed write for the scoreboard (clears busy).
- ZERO_R0=1 and A3=0: the write is discarded.
- Read: RDn = reg[An], combinational, zero-latency.
- ZERO_R0=1 and An=0: RDn=0 and BUSYn=0 regardless of anything else.
- Bypass (BYPASS=1) with WE3=1 and An==A3 in the same cycle: RDn returns the merged value, i.e. WD3 bytes where BE3=1 and stored bytes elsewhere. This is the value the register will hold after the edge.
- BYPASS=0: RDn returns the pre-edge stored value.
- Scoreboard, updated on the rising edge:
  - WE3=1 clears busy[A3].
  - ISS_EN=1 sets busy[ISS_A].
  - ISS_EN with ISS_A==A3 and WE3=1 in the same cycle: set wins, so busy stays 1 (the new instruction's write is now pending).
  - ISS_EN to an already-busy register: stays busy (no counting; one outstanding write per register).
  - ZERO_R0=1: busy[0] is forced to 0.
- BUSYn = busy[An]. With BYPASS=1, BUSYn=0 when WE3=1 and An==A3 in that cycle, because the data is being forwarded. With BYPASS=0 the raw busy bit is reported.
- BUSY_VEC reflects the registered busy bits only; it carries no bypass masking.
- Out-of-range addresses are impossible, since NREGS is a power of two.
- No other state. Implementation: regfile array, merge logic, bypass muxes, scoreboard.

Test Plan:
- Basic write and read: reset low then high. Write A3=10 WD3=32'hFF BE3=4'hF, then A3=5 WD3=32'h12F. Set A1=10, A2=5 -> RD1=32'hFF, RD2=32'h12F.
- Byte enables: reg 7 = 32'h11223344. Write WD3=32'hAABBCCDD with BE3=4'b0101 -> reg 7 = 32'h11BB33DD.
- Bypass: BYPASS=1, reg 3 = 32'h0. In the same cycle WE3=1, A3=3, WD3=32'hCAFE, A1=3 -> RD1=32'hCAFE before the edge and BUSY1=0. With BYPASS=0 -> RD1=0 before the edge, 32'hCAFE after.
- Register 0: ZERO_R0=1. Write A3=0 WD3=32'hDEAD and issue ISS_A=0 -> RD1(A1=0)=0, BUSY1=0, BUSY_VEC[0]=0.
- Scoreboard:
  - ISS_EN ISS_A=4 -> next cycle BUSY_VEC[4]=1, and A2=4 gives BUSY2=1.
  - Later WE3 A3=4 -> BUSY_VEC[4]=0 after the edge.
  - Simultaneous WE3 A3=4 and ISS_EN ISS_A=4 -> BUSY_VEC[4]=1.
- Async reset mid-operation: after the writes above, drive reset=0 between clock edges -> RD1, RD2 and BUSY_VEC are 0 with no clock edge. Release reset, read reg 10 -> 0.
